uart_mmio_fifo: RTL and testbench

Memory-mapped UART peripheral with parametrised TX/RX FIFOs, runtime control/status registers and a level interrupt. It sits on the CPU's data-memory side: it decodes a block of addresses above `BASE_ADDR`, and the top level muxes its `r_data` into the CPU read path. It replaces ad-hoc per-register decode at the top level with one self-contained, depth-configurable peripheral.

---
 rtl/uart_mmio_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_mmio_fifo.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared constants and FSM state types for the memory-mapped UART.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_mmio_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_RXDATA = 2'd3;

  // CTRL bit indices
  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_EN = 1;
  localparam int CTRL_RX_IE = 2;
  localparam int CTRL_TX_IE = 3;

  // STATUS bit indices
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_AVAIL  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_BUSY   = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy counter.
// Latency: a pushed entry is visible at head one cycle after the push edge.
// Backpressure: push while full (without a pop) is dropped; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop & ~empty;
  // A push at full is accepted only when a pop frees the slot in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, CTRL/STATUS registers and a level irq.
// Latency: TXDATA write at edge N -> tx falls after N+1; RX byte visible on the stop-sample edge.
// Backpressure: TX pushes at full are dropped; RX bytes arriving at full set overrun and are dropped.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'd248,
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] w_data,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] r_data,
  output logic       hit,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = 1;

  // ---------------- Address decode ----------------
  logic [1:0] off;
  logic       wr_ctrl, wr_status, wr_txdata, rd_rxdata;

  assign hit = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 9'd3));
  // Modulo-4 subtraction of the low bits gives the offset whenever hit is set
  assign off       = addr[1:0] - BASE_ADDR[1:0];
  assign wr_ctrl   = w_en & hit & (off == OFF_CTRL);
  assign wr_status = w_en & hit & (off == OFF_STATUS);
  assign wr_txdata = w_en & hit & (off == OFF_TXDATA);
  assign rd_rxdata = r_en & hit & (off == OFF_RXDATA);

  // ---------------- Registers and FIFOs ----------------
  logic [3:0]      ctrl;
  logic            overrun, frame_err;
  logic            tx_pop, rx_push, set_ovr, set_ferr;
  logic [7:0]      txf_head, rxf_head;
  logic            txf_full, txf_empty, rxf_full, rxf_empty;
  logic [CNTW-1:0] txf_count, rxf_count;
  logic [7:0]      rx_shift;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset_n(reset_n), .push(wr_txdata), .din(w_data), .pop(tx_pop),
    .head(txf_head), .full(txf_full), .empty(txf_empty), .count(txf_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset_n(reset_n), .push(rx_push), .din(rx_shift), .pop(rd_rxdata),
    .head(rxf_head), .full(rxf_full), .empty(rxf_empty), .count(rxf_count)
  );

  // CTRL register and sticky error bits; a new error event wins over a same-cycle clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl      <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= w_data[3:0];
      overrun   <= set_ovr  | (overrun   & ~(wr_status & w_data[ST_OVERRUN]));
      frame_err <= set_ferr | (frame_err & ~(wr_status & w_data[ST_FRAME_ERR]));
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_line, tx_line_n;
  logic          tx_go, tx_busy;

  assign tx_go   = ctrl[CTRL_TX_EN] & ~txf_empty;
  assign tx_busy = (tx_state != TX_IDLE);
  assign tx      = tx_line;

  // TX state register; line resets high asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX next state: STOP chains straight into START so queued frames run back-to-back
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (tx_go) begin
          tx_pop     = 1'b1;
          tx_shift_n = txf_head;
          tx_cnt_n   = '0;
          tx_line_n  = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_bit_n  = tx_bit + 3'd1;
            tx_line_n = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_go) begin
            tx_pop     = 1'b1;
            tx_shift_n = txf_head;
            tx_line_n  = 1'b0;
            tx_state_n = TX_START;
          end else begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- Receiver ----------------
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift_n;
  logic          rx_meta, rx_sync, rx_prev, rx_fall;

  assign rx_fall = rx_prev & ~rx_sync;

  // Synchronizer, edge-detect history and RX state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state: mid-start check rejects glitches, then one sample per bit period
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_ferr   = 1'b0;
    if (!ctrl[CTRL_RX_EN]) begin
      rx_state_n = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt_n   = '0;
            rx_state_n = RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_n = rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt_n   = '0;
            rx_shift_n = {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            else                rx_bit_n   = rx_bit + 3'd1;
          end else begin
            rx_cnt_n = rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt_n   = '0;
            rx_state_n = RX_IDLE;
            if (!rx_sync)      set_ferr = 1'b1;
            else if (rxf_full) set_ovr  = 1'b1;
            else               rx_push  = 1'b1;
          end else begin
            rx_cnt_n = rx_cnt + CNT_ONE;
          end
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  // ---------------- Status, read mux, interrupt ----------------
  logic [7:0] status;
  logic       tx_empty_st, rx_avail_st;

  // Status occupancy bits read the FIFO counters; control paths use the flags
  assign tx_empty_st = (txf_count == '0);
  assign rx_avail_st = (rxf_count != '0);
  assign status = {1'b0, tx_busy, frame_err, overrun, rxf_full, rx_avail_st, tx_empty_st, txf_full};

  // Combinational read data, zero outside the block
  always_comb begin
    r_data = 8'h00;
    if (hit) begin
      case (off)
        OFF_CTRL:   r_data = {4'b0000, ctrl};
        OFF_STATUS: r_data = status;
        OFF_TXDATA: r_data = 8'h00;
        OFF_RXDATA: r_data = rxf_empty ? 8'h00 : rxf_head;
        default:    r_data = 8'h00;
      endcase
    end
  end

  // Registered level interrupt
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else irq <= (ctrl[CTRL_RX_IE] & rx_avail_st) |
                (ctrl[CTRL_TX_IE] & tx_empty_st & ~tx_busy) |
                overrun | frame_err;
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo with CLK_DIV=4, FIFO_DEPTH=4.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_mmio_fifo;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [7:0] A_CTRL = 8'd248;
  localparam logic [7:0] A_STAT = 8'd249;
  localparam logic [7:0] A_TXD  = 8'd250;
  localparam logic [7:0] A_RXD  = 8'd251;

  logic       clock, reset_n;
  logic [7:0] addr, w_data, r_data;
  logic       w_en, r_en, hit, rx, tx, irq;
  int         n_cmp, n_bad;

  typedef struct {
    logic [7:0] a;
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic       exp_hit;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vt[18];

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_ovr, m_ferr, m_rxie, m_txie;

  uart_mmio_fifo #(.BASE_ADDR(8'd248), .CLK_DIV(C), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .w_data(w_data), .w_en(w_en),
    .r_en(r_en), .r_data(r_data), .hit(hit), .rx(rx), .tx(tx), .irq(irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; w_data = d; w_en = 1'b1;
    tick();
    w_en = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = r_data;
  endtask

  task automatic pop_rx(output logic [7:0] d);
    addr = A_RXD;
    #1;
    d = r_data;
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [7:0] exp);
    logic [7:0] d;
    peek(A_STAT, d);
    check(name, d, exp);
  endtask

  // Serial frame onto rx, one bit per C cycles
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (C) tick();
    end
    rx = 1'b1;
  endtask

  // Expects a frame to have started on the edge just passed
  task automatic tx_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    addr = A_STAT;
    #1;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < C; c++) begin
        check("tx_bit", {7'b0, tx}, {7'b0, f[i]});
        if (c == 1) check("tx_busy", {7'b0, r_data[6]}, 8'h01);
        tick();
      end
    end
  endtask

  function automatic logic [7:0] model_status();
    return {2'b00, m_ferr, m_ovr, rxq.size() == D, rxq.size() != 0,
            txq.size() == 0, txq.size() == D};
  endfunction

  function automatic logic model_irq();
    return (m_rxie & (rxq.size() != 0)) | (m_txie & (txq.size() == 0)) | m_ovr | m_ferr;
  endfunction

  initial begin
    logic [7:0] d, b, e;
    int         op;
    logic       stop_b, seen_low;

    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; addr = '0; w_data = '0; w_en = 1'b0; r_en = 1'b0; rx = 1'b1;

    vt[0]  = '{8'd247, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{8'd248, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vt[2]  = '{8'd249, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02};
    vt[3]  = '{8'd250, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vt[4]  = '{8'd251, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vt[5]  = '{8'd252, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{8'd0,   1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{8'd255, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00};
    vt[8]  = '{8'd248, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00};
    vt[9]  = '{8'd248, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0F};
    vt[10] = '{8'd249, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02};
    vt[11] = '{8'd249, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h02};
    vt[12] = '{8'd249, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02};
    vt[13] = '{8'd248, 1'b1, 8'h00, 1'b0, 1'b1, 8'h0F};
    vt[14] = '{8'd248, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
    vt[15] = '{8'd250, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vt[16] = '{8'd251, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vt[17] = '{8'd249, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02};

    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check_status("reset_status", 8'h02);
    check("reset_tx", {7'b0, tx}, 8'h01);
    check("reset_irq", {7'b0, irq}, 8'h00);

    // Register map vectors: check combinational outputs, then let the edge apply any write
    for (int i = 0; i < 18; i++) begin
      addr = vt[i].a; w_en = vt[i].we; w_data = vt[i].wd; r_en = vt[i].re;
      #1;
      check("vec_hit", {7'b0, hit}, {7'b0, vt[i].exp_hit});
      check("vec_rdata", r_data, vt[i].exp_rd);
      tick();
      w_en = 1'b0; r_en = 1'b0;
    end

    // Single TX frame A5 with start latency
    wr(A_CTRL, 8'h01);
    wr(A_TXD, 8'hA5);
    check("tx_before_pop", {7'b0, tx}, 8'h01);
    tick();
    tx_frame(8'hA5);
    check("tx_idle_after", {7'b0, tx}, 8'h01);
    check_status("tx_done_status", 8'h02);

    // Fill TX FIFO with transmitter disabled, then drain back-to-back
    wr(A_CTRL, 8'h00);
    for (int i = 0; i < 5; i++) wr(A_TXD, 8'h10 + 8'(i));
    check_status("tx_full_status", 8'h01);
    wr(A_CTRL, 8'h01);
    check("tx_hold_en", {7'b0, tx}, 8'h01);
    tick();
    for (int i = 0; i < 4; i++) tx_frame(8'h10 + 8'(i));
    check("tx_no_fifth", {7'b0, tx}, 8'h01);
    check_status("tx_drained", 8'h02);
    seen_low = 1'b0;
    for (int i = 0; i < 12 * C; i++) begin
      if (tx == 1'b0) seen_low = 1'b1;
      tick();
    end
    check("tx_dropped_byte", {7'b0, seen_low}, 8'h00);

    // Single RX frame with interrupt
    wr(A_CTRL, 8'h06);
    send_rx(8'h3C, 1'b1);
    repeat (2 * C) tick();
    check_status("rx_avail_status", 8'h06);
    check("rx_irq", {7'b0, irq}, 8'h01);
    peek(A_RXD, d);
    check("rx_head", d, 8'h3C);
    pop_rx(d);
    check("rx_pop_data", d, 8'h3C);
    check_status("rx_popped_status", 8'h02);
    tick();
    check("rx_irq_clear", {7'b0, irq}, 8'h00);

    // Overrun on the fifth unread frame
    for (int i = 0; i < 5; i++) begin
      send_rx(8'h41 + 8'(i), 1'b1);
      repeat (C) tick();
    end
    repeat (C) tick();
    check_status("ovr_status", 8'h1E);
    check("ovr_irq", {7'b0, irq}, 8'h01);
    wr(A_STAT, 8'h10);
    check_status("ovr_cleared", 8'h0E);
    for (int i = 0; i < 4; i++) begin
      pop_rx(d);
      check("ovr_fifo_data", d, 8'h41 + 8'(i));
    end
    check_status("ovr_drained", 8'h02);

    // Framing error, then glitch rejection
    send_rx(8'h55, 1'b0);
    repeat (2 * C) tick();
    check_status("ferr_status", 8'h22);
    check("ferr_irq", {7'b0, irq}, 8'h01);
    wr(A_STAT, 8'h20);
    check_status("ferr_cleared", 8'h02);
    tick(); tick();
    check("ferr_irq_clear", {7'b0, irq}, 8'h00);
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12 * C) tick();
    check_status("glitch_status", 8'h02);

    // Randomized traffic against the queue model (TX held off, RX enabled)
    m_ovr = 1'b0; m_ferr = 1'b0; m_rxie = 1'b1; m_txie = 1'b0;
    wr(A_CTRL, 8'h06);
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          b = 8'($urandom);
          stop_b = ($urandom_range(0, 5) != 0);
          send_rx(b, stop_b);
          if (!stop_b) m_ferr = 1'b1;
          else if (rxq.size() == D) m_ovr = 1'b1;
          else rxq.push_back(b);
          repeat (C) tick();
        end
        1: begin
          e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
          pop_rx(d);
          check("rnd_rxdata", d, e);
        end
        2: begin
          b = 8'($urandom);
          wr(A_TXD, b);
          if (txq.size() < D) txq.push_back(b);
        end
        3: begin
          b = 8'($urandom);
          wr(A_STAT, b);
          if (b[4]) m_ovr = 1'b0;
          if (b[5]) m_ferr = 1'b0;
        end
        default: begin
          m_rxie = 1'($urandom);
          m_txie = 1'($urandom);
          wr(A_CTRL, {4'b0000, m_txie, m_rxie, 2'b10});
        end
      endcase
      tick();
      check_status("rnd_status", model_status());
      check("rnd_irq", {7'b0, irq}, {7'b0, model_irq()});
    end

    // Drain what the model queued: transmit in order, then read back RX
    wr(A_CTRL, 8'h01);
    check("rnd_tx_pre", {7'b0, tx}, 8'h01);
    tick();
    while (txq.size() != 0) tx_frame(txq.pop_front());
    check("rnd_tx_idle", {7'b0, tx}, 8'h01);
    while (rxq.size() != 0) begin
      e = rxq.pop_front();
      pop_rx(d);
      check("rnd_rx_drain", d, e);
    end
    check_status("rnd_final_status", model_status());

    // Reset mid-frame: line returns high at once and queued data is lost
    wr(A_CTRL, 8'h01);
    wr(A_TXD, 8'h00);
    wr(A_TXD, 8'h00);
    repeat (3) tick();
    check("rst_tx_low", {7'b0, tx}, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_tx_async", {7'b0, tx}, 8'h01);
    check_status("rst_status", 8'h02);
    check("rst_irq", {7'b0, irq}, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    peek(A_CTRL, d);
    check("rst_ctrl", d, 8'h00);
    seen_low = 1'b0;
    for (int i = 0; i < 12 * C; i++) begin
      if (tx == 1'b0) seen_low = 1'b1;
      tick();
    end
    check("rst_fifo_lost", {7'b0, seen_low}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
